mem_stage: RTL and testbench

- Memory-access pipeline stage. Sits directly downstream of the execute stage and upstream of writeback.
- Registers the execute-to-memory bus under the global stall vector.
- Captures synchronous data-SRAM read data and holds it safely across stalls.
- Extracts and extends load bytes/halfwords, resolves the final register-file write value, and drives the writeback bus and the decode-stage forwarding bus.

---
 rtl/mem_stage_if.sv | 25 ++
 rtl/mem_stage.sv | 167 ++++++++++++++++
 tb/tb_mem_stage.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Execute-to-memory, SRAM read data, stall vector and the two result buses of the memory stage.
// The master drives the upstream side. The slave is the stage itself.
interface mem_stage_if;
   logic [5:0]   stall;
   logic [213:0] ex_to_mem_bus;
   logic [31:0]  data_sram_rdata;
   logic [135:0] mem_to_wb_bus;
   logic [103:0] mem_to_id_bus;

   modport master (
      output stall,
      output ex_to_mem_bus,
      output data_sram_rdata,
      input  mem_to_wb_bus,
      input  mem_to_id_bus
   );

   modport slave (
      input  stall,
      input  ex_to_mem_bus,
      input  data_sram_rdata,
      output mem_to_wb_bus,
      output mem_to_id_bus
   );
endinterface

// File: rtl/mem_stage.sv
// Memory pipeline stage: registers the EX bus, holds SRAM load data across stalls, and drives the WB and forwarding buses.
// One register stage on the input. Outputs are combinational from it, and stall[MEM] holds or bubbles the stage.
module mem_stage #(
   parameter int MEM_STALL_BIT = 3,
   parameter int WB_STALL_BIT  = 4
) (
   input logic       clk,
   input logic       rst,
   mem_stage_if.slave mif
);
   typedef struct packed {
      logic [5:0]  mem_op;
      logic        hi_we;
      logic [31:0] hi_wdata;
      logic        lo_we;
      logic [31:0] lo_wdata;
      logic        r_lo;
      logic [31:0] r_lo_data;
      logic        r_hi;
      logic [31:0] r_hi_data;
      logic [31:0] pc;
      logic        data_ram_en;
      logic [3:0]  data_ram_wen;
      logic        sel_rf_res;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] ex_result;
   } ex_mem_t;

   typedef struct packed {
      logic        hi_we;
      logic [31:0] hi_wdata;
      logic        lo_we;
      logic [31:0] lo_wdata;
      logic [31:0] pc;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] rf_wdata;
   } mem_wb_t;

   typedef struct packed {
      logic        hi_we;
      logic [31:0] hi_wdata;
      logic        lo_we;
      logic [31:0] lo_wdata;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] rf_wdata;
   } mem_id_t;

   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_LW  = 6'b100011;

   ex_mem_t     bus_r;
   logic        first_cycle;
   logic [31:0] rdata_hold;
   logic        hold_valid;

   logic        mem_stop;
   logic        wb_stop;
   logic        bubble;
   logic        advance;
   logic        is_load;
   logic        capture;
   logic        unused_stall_bits;

   assign mem_stop = mif.stall[MEM_STALL_BIT];
   assign wb_stop  = mif.stall[WB_STALL_BIT];
   assign bubble   = mem_stop & ~wb_stop;
   assign advance  = ~mem_stop;
   assign is_load  = bus_r.data_ram_en & (bus_r.data_ram_wen == 4'b0000);
   // The SRAM presents load data only in the load's first cycle here, so grab it before a stall loses it.
   assign capture  = mem_stop & wb_stop & first_cycle & is_load;
   // Only two bits of the shared stall vector belong to this stage.
   assign unused_stall_bits = ^mif.stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         bus_r       <= '0;
         first_cycle <= 1'b0;
         rdata_hold  <= '0;
         hold_valid  <= 1'b0;
      end else if (bubble) begin
         bus_r       <= '0;
         first_cycle <= 1'b1;
         hold_valid  <= 1'b0;
      end else if (advance) begin
         bus_r       <= ex_mem_t'(mif.ex_to_mem_bus);
         first_cycle <= 1'b1;
         hold_valid  <= 1'b0;
      end else begin
         first_cycle <= 1'b0;
         if (capture) begin
            rdata_hold <= mif.data_sram_rdata;
            hold_valid <= 1'b1;
         end
      end
   end

   logic [31:0] eff_rdata;
   logic [7:0]  load_byte;
   logic [15:0] load_half;
   logic [31:0] load_data;
   logic [31:0] rf_wdata;

   always_comb begin
      eff_rdata = hold_valid ? rdata_hold : mif.data_sram_rdata;

      load_byte = eff_rdata[7:0];
      case (bus_r.ex_result[1:0])
         2'd0:    load_byte = eff_rdata[7:0];
         2'd1:    load_byte = eff_rdata[15:8];
         2'd2:    load_byte = eff_rdata[23:16];
         default: load_byte = eff_rdata[31:24];
      endcase

      load_half = bus_r.ex_result[1] ? eff_rdata[31:16] : eff_rdata[15:0];

      load_data = eff_rdata;
      case (bus_r.mem_op)
         OP_LB:   load_data = {{24{load_byte[7]}}, load_byte};
         OP_LBU:  load_data = {24'd0, load_byte};
         OP_LH:   load_data = {{16{load_half[15]}}, load_half};
         OP_LHU:  load_data = {16'd0, load_half};
         OP_LW:   load_data = eff_rdata;
         default: load_data = eff_rdata;
      endcase

      if (bus_r.r_hi) begin
         rf_wdata = bus_r.r_hi_data;
      end else if (bus_r.r_lo) begin
         rf_wdata = bus_r.r_lo_data;
      end else if (bus_r.sel_rf_res) begin
         rf_wdata = load_data;
      end else begin
         rf_wdata = bus_r.ex_result;
      end
   end

   mem_wb_t wb_out;
   mem_id_t id_out;

   always_comb begin
      wb_out.hi_we    = bus_r.hi_we;
      wb_out.hi_wdata = bus_r.hi_wdata;
      wb_out.lo_we    = bus_r.lo_we;
      wb_out.lo_wdata = bus_r.lo_wdata;
      wb_out.pc       = bus_r.pc;
      wb_out.rf_we    = bus_r.rf_we;
      wb_out.rf_waddr = bus_r.rf_waddr;
      wb_out.rf_wdata = rf_wdata;

      id_out.hi_we    = bus_r.hi_we;
      id_out.hi_wdata = bus_r.hi_wdata;
      id_out.lo_we    = bus_r.lo_we;
      id_out.lo_wdata = bus_r.lo_wdata;
      id_out.rf_we    = bus_r.rf_we;
      id_out.rf_waddr = bus_r.rf_waddr;
      id_out.rf_wdata = rf_wdata;
   end

   assign mif.mem_to_wb_bus = wb_out;
   assign mif.mem_to_id_bus = id_out;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: literal expectations plus a per-cycle compare against a field-level model.
module tb_mem_stage;
   typedef struct packed {
      logic [5:0]  mem_op;
      logic        hi_we;
      logic [31:0] hi_wdata;
      logic        lo_we;
      logic [31:0] lo_wdata;
      logic        r_lo;
      logic [31:0] r_lo_data;
      logic        r_hi;
      logic [31:0] r_hi_data;
      logic [31:0] pc;
      logic        data_ram_en;
      logic [3:0]  data_ram_wen;
      logic        sel_rf_res;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] ex_result;
   } ex_t;

   localparam logic [5:0] GO    = 6'b000000;
   localparam logic [5:0] MSTOP = 6'b001111;
   localparam logic [5:0] HOLD  = 6'b011111;

   logic clk = 1'b0;
   logic rst = 1'b1;
   mem_stage_if mif ();

   mem_stage #(.MEM_STALL_BIT(3), .WB_STALL_BIT(4)) dut (
      .clk (clk),
      .rst (rst),
      .mif (mif)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit armed  = 1'b0;

   task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the instruction in MEM, how many cycles it has sat there, and the word it saw on arrival.
   ex_t         m_cur = '0;
   int          m_age = 0;
   logic [31:0] m_word = '0;

   function automatic logic [135:0] expect_wb(input ex_t b, input logic [31:0] rd);
      logic [31:0] wd;
      logic [7:0]  by;
      logic [15:0] hw;
      by = rd[8*b.ex_result[1:0] +: 8];
      hw = rd[16*b.ex_result[1] +: 16];
      if (b.r_hi)            wd = b.r_hi_data;
      else if (b.r_lo)       wd = b.r_lo_data;
      else if (b.sel_rf_res) begin
         case (b.mem_op)
            6'b100000: wd = {{24{by[7]}}, by};
            6'b100100: wd = {24'd0, by};
            6'b100001: wd = {{16{hw[15]}}, hw};
            6'b100101: wd = {16'd0, hw};
            default:   wd = rd;
         endcase
      end else               wd = b.ex_result;
      return {b.hi_we, b.hi_wdata, b.lo_we, b.lo_wdata, b.pc, b.rf_we, b.rf_waddr, wd};
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_cur = '0;
         m_age = 0;
      end else if (mif.stall[3] && !mif.stall[4]) begin
         m_cur = '0;
         m_age = 0;
      end else if (!mif.stall[3]) begin
         m_cur = ex_t'(mif.ex_to_mem_bus);
         m_age = 0;
      end else begin
         if (m_age == 0) m_word = mif.data_sram_rdata;
         m_age++;
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         logic [135:0] ew;
         logic [31:0]  rd;
         logic         ld;
         ld = m_cur.data_ram_en && (m_cur.data_ram_wen == 4'b0000);
         rd = (ld && m_age > 0) ? m_word : mif.data_sram_rdata;
         ew = expect_wb(m_cur, rd);
         check("model_wb", mif.mem_to_wb_bus, ew);
         check("model_id", {32'd0, mif.mem_to_id_bus}, {32'd0, ew[135:70], ew[37:0]});
      end
   end

   function automatic ex_t mk(input logic [5:0] op, input logic en, input logic [3:0] wen,
                              input logic sel, input logic we, input logic [4:0] wa, input logic [31:0] exr);
      ex_t e;
      e = '0;
      e.mem_op = op;
      e.data_ram_en = en;
      e.data_ram_wen = wen;
      e.sel_rf_res = sel;
      e.rf_we = we;
      e.rf_waddr = wa;
      e.ex_result = exr;
      e.pc = 32'hBFC0_0000 + exr;
      return e;
   endfunction

   task automatic step(input logic [5:0] st, input ex_t b, input logic [31:0] rd);
      mif.stall = st;
      mif.ex_to_mem_bus = b;
      mif.data_sram_rdata = rd;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [135:0] wdat();
      return {104'd0, mif.mem_to_wb_bus[31:0]};
   endfunction

   ex_t lb_b, lbu_b, lh_b, lhu_b, lw_b, mfhi_b, st_b, lw2_b, nop_b;

   initial begin
      lb_b  = mk(6'b100000, 1'b1, 4'b0000, 1'b1, 1'b1, 5'd5, 32'h0000_1002);
      lbu_b = mk(6'b100100, 1'b1, 4'b0000, 1'b1, 1'b1, 5'd5, 32'h0000_1002);
      lh_b  = mk(6'b100001, 1'b1, 4'b0000, 1'b1, 1'b1, 5'd6, 32'h0000_1000);
      lhu_b = mk(6'b100101, 1'b1, 4'b0000, 1'b1, 1'b1, 5'd7, 32'h0000_1002);
      lw_b  = mk(6'b100011, 1'b1, 4'b0000, 1'b1, 1'b1, 5'd8, 32'h0000_1004);
      lw2_b = mk(6'b100011, 1'b1, 4'b0000, 1'b1, 1'b1, 5'd3, 32'h0000_2000);
      st_b  = mk(6'b101011, 1'b1, 4'b1111, 1'b0, 1'b0, 5'd0, 32'hA5A5_0004);
      nop_b = mk(6'b000000, 1'b0, 4'b0000, 1'b0, 1'b0, 5'd0, 32'h0000_0000);
      mfhi_b = mk(6'b000000, 1'b0, 4'b0000, 1'b0, 1'b1, 5'd9, 32'h0000_0040);
      mfhi_b.r_hi = 1'b1;
      mfhi_b.r_hi_data = 32'hCAFE_F00D;
      mfhi_b.hi_we = 1'b1;
      mfhi_b.hi_wdata = 32'h0000_0001;

      // Reset with a live load at the input.
      rst = 1'b1;
      step(GO, lw_b, 32'h1111_1111);
      tick();
      rst = 1'b0;
      armed = 1'b1;
      step(HOLD, lb_b, 32'h0);
      check("rst_wb", mif.mem_to_wb_bus, 136'd0);
      check("rst_id", {32'd0, mif.mem_to_id_bus}, 136'd0);
      check("rst_hold_valid", {135'd0, dut.hold_valid}, 136'd0);
      tick();

      step(GO, lb_b, 32'h0);
      tick();
      step(GO, lbu_b, 32'h8899_AABB);
      check("lb", wdat(), 136'hFFFF_FF99);
      check("lb_waddr", {131'd0, mif.mem_to_wb_bus[36:32]}, 136'd5);
      tick();
      step(GO, lh_b, 32'h8899_AABB);
      check("lbu", wdat(), 136'h0000_0099);
      tick();
      step(GO, lhu_b, 32'h8899_AABB);
      check("lh", wdat(), 136'hFFFF_AABB);
      tick();
      step(GO, lw_b, 32'h8899_AABB);
      check("lhu_hi", wdat(), 136'h0000_8899);
      tick();

      // lw held for several cycles while the SRAM output moves on.
      step(HOLD, nop_b, 32'h1234_5678);
      check("lw_first", wdat(), 136'h1234_5678);
      tick();
      for (int i = 0; i < 3; i++) begin
         step(HOLD, nop_b, 32'hDEAD_BEEF);
         check("lw_stalled", wdat(), 136'h1234_5678);
         check("lw_hold_valid", {135'd0, dut.hold_valid}, 136'd1);
         tick();
      end
      step(GO, mfhi_b, 32'hDEAD_BEEF);
      check("lw_release", wdat(), 136'h1234_5678);
      tick();

      step(GO, st_b, 32'hDEAD_BEEF);
      check("mfhi_hold_valid", {135'd0, dut.hold_valid}, 136'd0);
      check("mfhi_wdata", wdat(), 136'hCAFE_F00D);
      check("mfhi_wb_waddr", {131'd0, mif.mem_to_wb_bus[36:32]}, 136'd9);
      check("mfhi_id_waddr", {131'd0, mif.mem_to_id_bus[36:32]}, 136'd9);
      check("mfhi_id_wdata", {104'd0, mif.mem_to_id_bus[31:0]}, 136'hCAFE_F00D);
      check("mfhi_hi", {103'd0, mif.mem_to_wb_bus[135:103]}, {103'd0, 1'b1, 32'h1});
      tick();

      // Store under stall: no capture, register write disabled.
      step(HOLD, lb_b, 32'h5555_5555);
      check("st_wdata", wdat(), 136'hA5A5_0004);
      check("st_rf_we", {135'd0, mif.mem_to_wb_bus[37]}, 136'd0);
      tick();
      step(HOLD, lb_b, 32'h6666_6666);
      check("st_hold_valid", {135'd0, dut.hold_valid}, 136'd0);
      check("st_held", wdat(), 136'hA5A5_0004);
      tick();
      step(MSTOP, lb_b, 32'h0);
      check("pre_bubble", wdat(), 136'hA5A5_0004);
      tick();
      step(HOLD, lb_b, 32'h0);
      check("bubble_wb", mif.mem_to_wb_bus, 136'd0);
      check("bubble_id", {32'd0, mif.mem_to_id_bus}, 136'd0);
      tick();

      // Reset arriving while a captured load is stalled.
      step(GO, lw2_b, 32'h0);
      tick();
      step(HOLD, nop_b, 32'h1111_2222);
      tick();
      rst = 1'b1;
      step(HOLD, nop_b, 32'h3333_3333);
      check("lw2_held", wdat(), 136'h1111_2222);
      check("lw2_hold_valid", {135'd0, dut.hold_valid}, 136'd1);
      tick();
      rst = 1'b0;
      step(HOLD, lw2_b, 32'h4444_4444);
      check("midrst_wb", mif.mem_to_wb_bus, 136'd0);
      check("midrst_hold_valid", {135'd0, dut.hold_valid}, 136'd0);
      tick();
      step(GO, lw2_b, 32'h0);
      tick();
      step(GO, nop_b, 32'h7777_8888);
      check("lw2_live", wdat(), 136'h7777_8888);
      tick();
      step(GO, nop_b, 32'h0);
      tick();
      tick();

      armed = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
